// File: rtl/ram_arb_if.sv
// Request/response bundle between the CPU data side, the host debug loader and the shared RAM port.
// The arbiter takes the slave modport; the requesters and the RAM model take the master modport.
interface ram_arb_if #(
  parameter int XLEN = 32,
  parameter int AW   = 32
);
  logic              cpu_req_i;
  logic              cpu_we_i;
  logic [AW-1:0]     cpu_addr_i;
  logic [XLEN-1:0]   cpu_wdata_i;
  logic [XLEN/8-1:0] cpu_be_i;
  logic              cpu_gnt_o;
  logic              cpu_rvld_o;
  logic [XLEN-1:0]   cpu_rdata_o;

  logic              host_req_i;
  logic              host_we_i;
  logic [AW-1:0]     host_addr_i;
  logic [XLEN-1:0]   host_wdata_i;
  logic [XLEN/8-1:0] host_be_i;
  logic              host_gnt_o;
  logic              host_rvld_o;
  logic [XLEN-1:0]   host_rdata_o;

  logic              ram_en_o;
  logic              ram_we_o;
  logic [AW-1:0]     ram_addr_o;
  logic [XLEN-1:0]   ram_wdata_o;
  logic [XLEN/8-1:0] ram_be_o;
  logic [XLEN-1:0]   ram_rdata_i;

  modport slave (
    input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i, cpu_be_i,
    output cpu_gnt_o, cpu_rvld_o, cpu_rdata_o,
    input  host_req_i, host_we_i, host_addr_i, host_wdata_i, host_be_i,
    output host_gnt_o, host_rvld_o, host_rdata_o,
    output ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o, ram_be_o,
    input  ram_rdata_i
  );

  modport master (
    output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i, cpu_be_i,
    input  cpu_gnt_o, cpu_rvld_o, cpu_rdata_o,
    output host_req_i, host_we_i, host_addr_i, host_wdata_i, host_be_i,
    input  host_gnt_o, host_rvld_o, host_rdata_o,
    input  ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o, ram_be_o,
    output ram_rdata_i
  );
endinterface

// File: rtl/ram_arb.sv
// Shares one synchronous RAM port between the CPU (fixed priority) and the host debug path,
// with a starvation counter that periodically forces a single host grant.
module ram_arb #(
  parameter int XLEN       = 32,
  parameter int AW         = 32,
  parameter int RD_LAT     = 1,
  parameter int STARVE_LIM = 16
) (
  input logic       clk_i,
  input logic       rst_i,
  ram_arb_if.slave  bus
);
  localparam int BW = XLEN / 8;

  logic [7:0]      starve_cnt;
  logic            force_host;
  logic            cpu_gnt;
  logic            host_gnt;
  logic            rd_push;
  logic [RD_LAT:0] tag_vld;
  logic [RD_LAT:0] tag_host;
  logic            cpu_rvld;
  logic            host_rvld;

  logic            ram_en;
  logic            ram_we;
  logic [AW-1:0]   ram_addr;
  logic [XLEN-1:0] ram_wdata;
  logic [BW-1:0]   ram_be;

  assign force_host = (starve_cnt >= 8'(STARVE_LIM));
  assign cpu_gnt    = ~rst_i & bus.cpu_req_i & ~(force_host & bus.host_req_i);
  assign host_gnt   = ~rst_i & bus.host_req_i & (~bus.cpu_req_i | force_host);
  assign rd_push    = (cpu_gnt & ~bus.cpu_we_i) | (host_gnt & ~bus.host_we_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ram_en     <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      ram_be     <= '0;
      starve_cnt <= '0;
      tag_vld    <= '0;
      tag_host   <= '0;
    end else begin
      if (cpu_gnt) begin
        ram_en    <= 1'b1;
        ram_we    <= bus.cpu_we_i;
        ram_addr  <= bus.cpu_addr_i;
        ram_wdata <= bus.cpu_wdata_i;
        ram_be    <= bus.cpu_be_i;
      end else if (host_gnt) begin
        ram_en    <= 1'b1;
        ram_we    <= bus.host_we_i;
        ram_addr  <= bus.host_addr_i;
        ram_wdata <= bus.host_wdata_i;
        ram_be    <= bus.host_be_i;
      end else begin
        ram_en <= 1'b0;
        ram_we <= 1'b0;
      end

      // A forced grant clears the count, so forcing never lasts more than one cycle.
      if (bus.host_req_i & ~host_gnt) begin
        if (starve_cnt != 8'hFF) starve_cnt <= starve_cnt + 8'd1;
      end else begin
        starve_cnt <= '0;
      end

      // Stage k holds the tag of the read granted k+1 cycles ago; the top stage lines up with RAM data.
      tag_vld  <= {tag_vld[RD_LAT-1:0], rd_push};
      tag_host <= {tag_host[RD_LAT-1:0], host_gnt};
    end
  end

  assign cpu_rvld  = tag_vld[RD_LAT] & ~tag_host[RD_LAT];
  assign host_rvld = tag_vld[RD_LAT] & tag_host[RD_LAT];

  assign bus.cpu_gnt_o    = cpu_gnt;
  assign bus.host_gnt_o   = host_gnt;
  assign bus.cpu_rvld_o   = cpu_rvld;
  assign bus.host_rvld_o  = host_rvld;
  assign bus.cpu_rdata_o  = cpu_rvld  ? bus.ram_rdata_i : '0;
  assign bus.host_rdata_o = host_rvld ? bus.ram_rdata_i : '0;

  assign bus.ram_en_o    = ram_en;
  assign bus.ram_we_o    = ram_we;
  assign bus.ram_addr_o  = ram_addr;
  assign bus.ram_wdata_o = ram_wdata;
  assign bus.ram_be_o    = ram_be;
endmodule

// File: tb/tb_ram_arb.sv
// Drives two arbiters (read latency 1 and 3, starvation limit 4) with identical traffic and
// compares every output each cycle against a cycle-level reference model of the arbitration rules.
module tb_ram_arb;
  localparam int SL   = 4;
  localparam int MAXC = 4096;

  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  ram_arb_if #(.XLEN(32), .AW(32)) b1 ();
  ram_arb_if #(.XLEN(32), .AW(32)) b3 ();

  ram_arb #(.XLEN(32), .AW(32), .RD_LAT(1), .STARVE_LIM(SL)) dut1 (
    .clk_i(clk_i), .rst_i(rst_i), .bus(b1.slave));
  ram_arb #(.XLEN(32), .AW(32), .RD_LAT(3), .STARVE_LIM(SL)) dut3 (
    .clk_i(clk_i), .rst_i(rst_i), .bus(b3.slave));

  logic        creq, cwe, hreq, hwe;
  logic [31:0] caddr, cwd, haddr, hwd, rdata;
  logic [3:0]  cbe, hbe;

  assign b1.cpu_req_i = creq;   assign b3.cpu_req_i = creq;
  assign b1.cpu_we_i = cwe;     assign b3.cpu_we_i = cwe;
  assign b1.cpu_addr_i = caddr; assign b3.cpu_addr_i = caddr;
  assign b1.cpu_wdata_i = cwd;  assign b3.cpu_wdata_i = cwd;
  assign b1.cpu_be_i = cbe;     assign b3.cpu_be_i = cbe;
  assign b1.host_req_i = hreq;  assign b3.host_req_i = hreq;
  assign b1.host_we_i = hwe;    assign b3.host_we_i = hwe;
  assign b1.host_addr_i = haddr; assign b3.host_addr_i = haddr;
  assign b1.host_wdata_i = hwd; assign b3.host_wdata_i = hwd;
  assign b1.host_be_i = hbe;    assign b3.host_be_i = hbe;
  assign b1.ram_rdata_i = rdata; assign b3.ram_rdata_i = rdata;

  int tests = 0;
  int fails = 0;

  // Reference model state
  int          cyc = 0;
  int          rst_mark = -1;
  int          starve = 0;
  bit          last_gc, last_gh;
  logic        exp_en, exp_we;
  logic [31:0] exp_addr, exp_wd;
  logic [3:0]  exp_be;
  bit          tag_v [MAXC];
  bit          tag_h [MAXC];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Expected response of a read granted in cycle k: it comes back in cycle k+1+lat.
  task automatic exp_resp(input int lat, output bit cv, output bit hv);
    int k;
    k  = cyc - 1 - lat;
    cv = 1'b0;
    hv = 1'b0;
    if (k >= 0 && k > rst_mark && tag_v[k]) begin
      cv = !tag_h[k];
      hv = tag_h[k];
    end
  endtask

  task automatic tick();
    bit force_h, gc, gh, cv1, hv1, cv3, hv3;
    #4;
    if (rst_i) begin
      starve = 0; rst_mark = cyc;
      exp_en = 0; exp_we = 0; exp_addr = 0; exp_wd = 0; exp_be = 0;
    end
    force_h = (starve >= SL);
    gc = !rst_i && creq && !(force_h && hreq);
    gh = !rst_i && hreq && (!creq || force_h);

    chk("d1_cpu_gnt", b1.cpu_gnt_o, gc);   chk("d3_cpu_gnt", b3.cpu_gnt_o, gc);
    chk("d1_host_gnt", b1.host_gnt_o, gh); chk("d3_host_gnt", b3.host_gnt_o, gh);
    chk("d1_ram_en", b1.ram_en_o, exp_en); chk("d3_ram_en", b3.ram_en_o, exp_en);
    chk("d1_ram_we", b1.ram_we_o, exp_we); chk("d3_ram_we", b3.ram_we_o, exp_we);
    chk("d1_ram_addr", b1.ram_addr_o, exp_addr);  chk("d3_ram_addr", b3.ram_addr_o, exp_addr);
    chk("d1_ram_wdata", b1.ram_wdata_o, exp_wd);  chk("d3_ram_wdata", b3.ram_wdata_o, exp_wd);
    chk("d1_ram_be", b1.ram_be_o, exp_be);        chk("d3_ram_be", b3.ram_be_o, exp_be);

    exp_resp(1, cv1, hv1);
    exp_resp(3, cv3, hv3);
    chk("d1_cpu_rvld", b1.cpu_rvld_o, cv1);   chk("d1_host_rvld", b1.host_rvld_o, hv1);
    chk("d3_cpu_rvld", b3.cpu_rvld_o, cv3);   chk("d3_host_rvld", b3.host_rvld_o, hv3);
    chk("d1_cpu_rdata", b1.cpu_rdata_o, cv1 ? rdata : 32'h0);
    chk("d1_host_rdata", b1.host_rdata_o, hv1 ? rdata : 32'h0);
    chk("d3_cpu_rdata", b3.cpu_rdata_o, cv3 ? rdata : 32'h0);
    chk("d3_host_rdata", b3.host_rdata_o, hv3 ? rdata : 32'h0);

    tag_v[cyc] = (gc && !cwe) || (gh && !hwe);
    tag_h[cyc] = gh;
    if (gc) begin
      exp_en = 1; exp_we = cwe; exp_addr = caddr; exp_wd = cwd; exp_be = cbe;
    end else if (gh) begin
      exp_en = 1; exp_we = hwe; exp_addr = haddr; exp_wd = hwd; exp_be = hbe;
    end else begin
      exp_en = 0; exp_we = 0;
    end
    if (!rst_i && hreq && !gh) starve = (starve < 255) ? starve + 1 : 255;
    else starve = 0;
    last_gc = gc;
    last_gh = gh;
    if (cyc < MAXC - 1) cyc++;
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_cpu(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] be);
    creq = r; cwe = w; caddr = a; cwd = d; cbe = be;
  endtask

  task automatic set_host(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] be);
    hreq = r; hwe = w; haddr = a; hwd = d; hbe = be;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1;
    rdata = 32'h0;
    set_cpu(0, 0, 0, 0, 0);
    set_host(0, 0, 0, 0, 0);
    @(posedge clk_i);
    #1;
    tick();
    tick();
    rst_i = 1'b0;
    tick();

    // Host read alone, data returned two cycles later on the latency-1 instance
    set_host(1, 0, 32'h10, 32'h0, 4'hF);
    tick();
    set_host(0, 0, 32'h10, 32'h0, 4'hF);
    tick();
    rdata = 32'hDEADBEEF;
    tick();
    rdata = 32'h0BADF00D;
    tick();
    tick();
    rdata = 32'h0;
    tick();

    // Contention: CPU holds priority for 4 cycles, then one forced host grant
    set_cpu(1, 0, 32'h100, 32'h0, 4'hF);
    set_host(1, 0, 32'h200, 32'h0, 4'hF);
    for (int i = 0; i < 10; i++) begin
      rdata = $urandom;
      tick();
    end
    set_cpu(0, 0, 0, 0, 0);
    set_host(0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      rdata = $urandom;
      tick();
    end

    // CPU write then read of the same word
    set_cpu(1, 1, 32'h20, 32'h12345678, 4'hF);
    tick();
    set_cpu(1, 0, 32'h20, 32'h0, 4'hF);
    tick();
    set_cpu(0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      rdata = $urandom;
      tick();
    end

    // Interleaved CPU then host reads
    set_cpu(1, 0, 32'h30, 32'h0, 4'hF);
    tick();
    set_cpu(0, 0, 0, 0, 0);
    set_host(1, 0, 32'h40, 32'h0, 4'hF);
    tick();
    set_host(0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      rdata = $urandom;
      tick();
    end

    // Reset while a latency-3 read is in flight
    set_cpu(1, 0, 32'h50, 32'h0, 4'hF);
    tick();
    set_cpu(0, 0, 0, 0, 0);
    rdata = 32'hA5A5A5A5;
    tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rdata = $urandom;
      tick();
    end

    // Host withdraws after 3 denied cycles; forcing needs 4 fresh denied cycles
    set_cpu(1, 0, 32'h60, 32'h0, 4'hF);
    set_host(1, 0, 32'h70, 32'h0, 4'hF);
    for (int i = 0; i < 3; i++) tick();
    set_host(0, 0, 32'h70, 32'h0, 4'hF);
    tick();
    set_host(1, 0, 32'h74, 32'h0, 4'hF);
    for (int i = 0; i < 6; i++) begin
      if (last_gh) set_host(0, 0, 0, 0, 0);
      tick();
    end
    set_cpu(0, 0, 0, 0, 0);
    set_host(0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) tick();

    // Random traffic honouring the hold-until-grant rule, with occasional resets
    for (int i = 0; i < 1500; i++) begin
      if (!(creq && !last_gc) || rst_i)
        set_cpu(($urandom % 4) != 0, $urandom % 2, $urandom, $urandom, 4'($urandom));
      if (!(hreq && !last_gh) || rst_i)
        set_host(($urandom % 2) != 0, $urandom % 2, $urandom, $urandom, 4'($urandom));
      rst_i = (($urandom % 200) == 0);
      rdata = $urandom;
      tick();
    end
    rst_i = 1'b0;
    set_cpu(0, 0, 0, 0, 0);
    set_host(0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
